// File: rtl/binary_target_box.sv
// binary_target_box: bounding box of thresholded pixels within a detection window,
// latched at each frame start and drawn as a coloured border on the next frame.
`default_nettype none

module binary_target_box #(
    parameter logic [23:0] BOX_COLOR  = 24'hFF0000,
    parameter int          LINE_W     = 2,
    parameter int          MIN_PIXELS = 64,
    parameter int          WIN_X0     = 31,
    parameter int          WIN_X1     = 449,
    parameter int          WIN_Y0     = 31,
    parameter int          WIN_Y1     = 239
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_flag,
    input  logic [23:0] i_data,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [23:0] o_data,
    output logic        box_valid,
    output logic [11:0] box_x0,
    output logic [11:0] box_x1,
    output logic [11:0] box_y0,
    output logic [11:0] box_y1,
    output logic [19:0] pix_count
);

    localparam logic [11:0] c_WIN_X0 = 12'(WIN_X0);
    localparam logic [11:0] c_WIN_X1 = 12'(WIN_X1);
    localparam logic [11:0] c_WIN_Y0 = 12'(WIN_Y0);
    localparam logic [11:0] c_WIN_Y1 = 12'(WIN_Y1);
    localparam logic [19:0] c_MIN    = 20'(MIN_PIXELS);
    localparam logic [12:0] c_LW     = 13'(LINE_W);
    localparam logic [19:0] c_SAT    = 20'hFFFFF;

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        ACCUM      = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_vs_d;
    logic [11:0] r_min_x, r_max_x, r_min_y, r_max_y;
    logic [19:0] r_count;

    logic w_fe;
    logic w_qual;
    logic w_inside;
    logic w_edge;
    logic w_border;

    assign w_fe   = i_vs & ~r_vs_d;
    assign w_qual = i_de & i_flag &
                    (i_x >= c_WIN_X0) & (i_x <= c_WIN_X1) &
                    (i_y >= c_WIN_Y0) & (i_y <= c_WIN_Y1);

    // 13-bit sums keep the edge test correct near the top of the 12-bit range
    assign w_inside = (i_x >= box_x0) & (i_x <= box_x1) &
                      (i_y >= box_y0) & (i_y <= box_y1);
    assign w_edge   = ({1'b0, i_x} < ({1'b0, box_x0} + c_LW)) |
                      (({1'b0, i_x} + c_LW) > {1'b0, box_x1}) |
                      ({1'b0, i_y} < ({1'b0, box_y0} + c_LW)) |
                      (({1'b0, i_y} + c_LW) > {1'b0, box_y1});
    assign w_border = w_inside & w_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= WAIT_FRAME;
            r_vs_d    <= 1'b0;
            r_min_x   <= 12'hFFF;
            r_max_x   <= 12'h000;
            r_min_y   <= 12'hFFF;
            r_max_y   <= 12'h000;
            r_count   <= 20'd0;
            o_hs      <= 1'b0;
            o_vs      <= 1'b0;
            o_de      <= 1'b0;
            o_data    <= 24'd0;
            box_valid <= 1'b0;
            box_x0    <= 12'd0;
            box_x1    <= 12'd0;
            box_y0    <= 12'd0;
            box_y1    <= 12'd0;
            pix_count <= 20'd0;
        end else begin
            r_vs_d <= i_vs;
            o_hs   <= i_hs;
            o_vs   <= i_vs;
            o_de   <= i_de;

            if (!i_de)
                o_data <= 24'd0;
            else if (en && box_valid && w_border)
                o_data <= BOX_COLOR;
            else
                o_data <= i_data;

            if (w_fe) begin
                r_state <= ACCUM;
                r_min_x <= 12'hFFF;
                r_max_x <= 12'h000;
                r_min_y <= 12'hFFF;
                r_max_y <= 12'h000;
                r_count <= 20'd0;
                // The partial frame seen before the first frame event is discarded
                if (r_state == ACCUM) begin
                    pix_count <= r_count;
                    if (r_count >= c_MIN) begin
                        box_valid <= 1'b1;
                        box_x0    <= r_min_x;
                        box_x1    <= r_max_x;
                        box_y0    <= r_min_y;
                        box_y1    <= r_max_y;
                    end else begin
                        box_valid <= 1'b0;
                    end
                end
            end else if (r_state == ACCUM && w_qual) begin
                if (i_x < r_min_x) r_min_x <= i_x;
                if (i_x > r_max_x) r_max_x <= i_x;
                if (i_y < r_min_y) r_min_y <= i_y;
                if (i_y > r_max_y) r_max_y <= i_y;
                if (r_count != c_SAT) r_count <= r_count + 20'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_binary_target_box.sv
// tb_binary_target_box: directed self-checking bench for binary_target_box.
`default_nettype none

module tb_binary_target_box;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        i_hs, i_vs, i_de, i_flag;
    logic [11:0] i_x, i_y;
    logic [23:0] i_data;
    logic        o_hs, o_vs, o_de;
    logic [23:0] o_data;
    logic        box_valid;
    logic [11:0] box_x0, box_x1, box_y0, box_y1;
    logic [19:0] pix_count;

    int n_cmp = 0;
    int n_bad = 0;

    binary_target_box dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y),
        .i_flag(i_flag), .i_data(i_data),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data),
        .box_valid(box_valid), .box_x0(box_x0), .box_x1(box_x1),
        .box_y0(box_y0), .box_y1(box_y1), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    // Inputs are applied 1 time unit after a rising edge, outputs read 1 unit after the next
    task automatic step(input logic vs, input logic de, input logic flag,
                        input logic [11:0] x, input logic [11:0] y, input logic [23:0] d);
        i_vs = vs; i_de = de; i_flag = flag; i_x = x; i_y = y; i_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        step(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 24'd0);
        step(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 24'd0);
        step(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 24'd0);
    endtask

    task automatic drive_block(input int x0, input int w, input int y0, input int h);
        for (int yy = y0; yy < y0 + h; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                step(1'b0, 1'b1, 1'b1, 12'(xx), 12'(yy), 24'h0A0B0C);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; i_hs = 1'b0;
        step(1'b0, 1'b1, 1'b1, 12'd100, 12'd100, 24'h555555);
        step(1'b0, 1'b1, 1'b1, 12'd100, 12'd100, 24'h555555);
        n_cmp++; if (o_data !== 24'd0) begin n_bad++; $display("FAIL reset_o_data: got %h want 000000", o_data); end
        n_cmp++; if ({o_hs, o_vs, o_de} !== 3'b000) begin n_bad++; $display("FAIL reset_sync: got %b want 000", {o_hs, o_vs, o_de}); end
        n_cmp++; if ({box_valid, box_x0, box_x1, box_y0, box_y1} !== 49'd0) begin n_bad++; $display("FAIL reset_box: got %0d %0d %0d %0d %0d want all 0", box_valid, box_x0, box_x1, box_y0, box_y1); end
        n_cmp++; if (pix_count !== 20'd0) begin n_bad++; $display("FAIL reset_pix_count: got %0d want 0", pix_count); end
        rst_n = 1'b1;
        drive_block(40, 10, 40, 10);
        frame_start();
        n_cmp++; if (box_valid !== 1'b0) begin n_bad++; $display("FAIL partial_frame_valid: got %0d want 0", box_valid); end
        n_cmp++; if (pix_count !== 20'd0) begin n_bad++; $display("FAIL partial_frame_count: got %0d want 0", pix_count); end
    endtask

    task automatic test_box();
        drive_block(100, 20, 50, 10);
        frame_start();
        n_cmp++; if (box_valid !== 1'b1) begin n_bad++; $display("FAIL box_valid: got %0d want 1", box_valid); end
        n_cmp++; if ({box_x0, box_x1, box_y0, box_y1} !== {12'd100, 12'd119, 12'd50, 12'd59}) begin n_bad++; $display("FAIL box_coords: got %0d %0d %0d %0d want 100 119 50 59", box_x0, box_x1, box_y0, box_y1); end
        n_cmp++; if (pix_count !== 20'd200) begin n_bad++; $display("FAIL box_count: got %0d want 200", pix_count); end
        // Overlay frame
        en = 1'b1;
        i_hs = 1'b1;
        step(1'b0, 1'b1, 1'b0, 12'd100, 12'd55, 24'h123456);
        n_cmp++; if (o_data !== 24'hFF0000) begin n_bad++; $display("FAIL ovl_left_edge: got %h want ff0000", o_data); end
        n_cmp++; if ({o_hs, o_de} !== 2'b11) begin n_bad++; $display("FAIL ovl_sync: got %b want 11", {o_hs, o_de}); end
        i_hs = 1'b0;
        i_data = 24'h777777;
        n_cmp++; if (o_data !== 24'hFF0000) begin n_bad++; $display("FAIL ovl_latency_hold: got %h want ff0000", o_data); end
        step(1'b0, 1'b1, 1'b0, 12'd110, 12'd51, 24'h123456);
        n_cmp++; if (o_data !== 24'hFF0000) begin n_bad++; $display("FAIL ovl_top_edge: got %h want ff0000", o_data); end
        step(1'b0, 1'b1, 1'b0, 12'd102, 12'd55, 24'h234567);
        n_cmp++; if (o_data !== 24'h234567) begin n_bad++; $display("FAIL ovl_interior: got %h want 234567", o_data); end
        step(1'b0, 1'b1, 1'b0, 12'd118, 12'd55, 24'h345678);
        n_cmp++; if (o_data !== 24'hFF0000) begin n_bad++; $display("FAIL ovl_right_edge: got %h want ff0000", o_data); end
        step(1'b0, 1'b1, 1'b0, 12'd99, 12'd55, 24'h456789);
        n_cmp++; if (o_data !== 24'h456789) begin n_bad++; $display("FAIL ovl_outside: got %h want 456789", o_data); end
        step(1'b0, 1'b0, 1'b0, 12'd100, 12'd55, 24'h56789A);
        n_cmp++; if (o_data !== 24'd0) begin n_bad++; $display("FAIL ovl_blank: got %h want 000000", o_data); end
        drive_block(100, 20, 50, 10);
        frame_start();
        n_cmp++; if (box_valid !== 1'b1) begin n_bad++; $display("FAIL box_relatch_valid: got %0d want 1", box_valid); end
    endtask

    task automatic test_below_min();
        drive_block(200, 63, 100, 1);
        frame_start();
        n_cmp++; if (box_valid !== 1'b0) begin n_bad++; $display("FAIL min_valid: got %0d want 0", box_valid); end
        n_cmp++; if (pix_count !== 20'd63) begin n_bad++; $display("FAIL min_count: got %0d want 63", pix_count); end
        n_cmp++; if ({box_x0, box_x1, box_y0, box_y1} !== {12'd100, 12'd119, 12'd50, 12'd59}) begin n_bad++; $display("FAIL min_box_hold: got %0d %0d %0d %0d want 100 119 50 59", box_x0, box_x1, box_y0, box_y1); end
        step(1'b0, 1'b1, 1'b0, 12'd100, 12'd55, 24'h13579B);
        n_cmp++; if (o_data !== 24'h13579B) begin n_bad++; $display("FAIL min_no_overlay: got %h want 13579b", o_data); end
    endtask

    task automatic test_window();
        step(1'b0, 1'b1, 1'b1, 12'd10, 12'd55, 24'h1);
        step(1'b0, 1'b1, 1'b1, 12'd110, 12'd300, 24'h1);
        step(1'b0, 1'b1, 1'b1, 12'd30, 12'd100, 24'h1);
        step(1'b0, 1'b1, 1'b1, 12'd450, 12'd100, 24'h1);
        step(1'b0, 1'b1, 1'b1, 12'd100, 12'd240, 24'h1);
        step(1'b0, 1'b0, 1'b1, 12'd90, 12'd40, 24'h1);
        step(1'b0, 1'b1, 1'b1, 12'd449, 12'd239, 24'h1);
        drive_block(150, 10, 60, 10);
        frame_start();
        n_cmp++; if (box_valid !== 1'b1) begin n_bad++; $display("FAIL win_valid: got %0d want 1", box_valid); end
        n_cmp++; if ({box_x0, box_x1, box_y0, box_y1} !== {12'd150, 12'd449, 12'd60, 12'd239}) begin n_bad++; $display("FAIL win_box: got %0d %0d %0d %0d want 150 449 60 239", box_x0, box_x1, box_y0, box_y1); end
        n_cmp++; if (pix_count !== 20'd101) begin n_bad++; $display("FAIL win_count: got %0d want 101", pix_count); end
    endtask

    task automatic test_fe_en();
        drive_block(200, 10, 100, 10);
        en = 1'b0;
        step(1'b0, 1'b1, 1'b0, 12'd449, 12'd100, 24'hABCDEF);
        n_cmp++; if (o_data !== 24'hABCDEF) begin n_bad++; $display("FAIL en0_passthru: got %h want abcdef", o_data); end
        en = 1'b1;
        step(1'b0, 1'b1, 1'b0, 12'd449, 12'd100, 24'hABCDEF);
        n_cmp++; if (o_data !== 24'hFF0000) begin n_bad++; $display("FAIL en1_overlay: got %h want ff0000", o_data); end
        en = 1'b0;
        // Flagged in-window pixel on the frame event cycle itself
        step(1'b1, 1'b1, 1'b1, 12'd50, 12'd50, 24'h1);
        step(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 24'h0);
        n_cmp++; if (pix_count !== 20'd100) begin n_bad++; $display("FAIL fe_count: got %0d want 100", pix_count); end
        n_cmp++; if ({box_valid, box_x0, box_x1, box_y0, box_y1} !== {1'b1, 12'd200, 12'd209, 12'd100, 12'd109}) begin n_bad++; $display("FAIL fe_box: got %0d %0d %0d %0d %0d want 1 200 209 100 109", box_valid, box_x0, box_x1, box_y0, box_y1); end
        frame_start();
        n_cmp++; if ({box_valid, pix_count} !== {1'b0, 20'd0}) begin n_bad++; $display("FAIL fe_dropped: got valid %0d count %0d want 0 0", box_valid, pix_count); end
        en = 1'b1;
    endtask

    task automatic test_mid_reset();
        drive_block(200, 10, 100, 10);
        frame_start();
        n_cmp++; if (box_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid: got %0d want 1", box_valid); end
        drive_block(60, 10, 60, 10);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({box_valid, pix_count, o_de} !== 22'd0) begin n_bad++; $display("FAIL async_reset: got valid %0d count %0d de %0d want 0 0 0", box_valid, pix_count, o_de); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_block(60, 10, 60, 10);
        frame_start();
        n_cmp++; if ({box_valid, pix_count} !== {1'b0, 20'd0}) begin n_bad++; $display("FAIL post_reset_frame: got valid %0d count %0d want 0 0", box_valid, pix_count); end
        drive_block(60, 10, 60, 10);
        frame_start();
        n_cmp++; if ({box_valid, box_x0, box_x1, box_y0, box_y1, pix_count} !== {1'b1, 12'd60, 12'd69, 12'd60, 12'd69, 20'd100}) begin n_bad++; $display("FAIL post_reset_box: got %0d %0d %0d %0d %0d %0d want 1 60 69 60 69 100", box_valid, box_x0, box_x1, box_y0, box_y1, pix_count); end
    endtask

    initial begin
        test_reset();
        test_box();
        test_below_min();
        test_window();
        test_fe_en();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/binary_target_box.md
Name: binary_target_box

Overview:
- Downstream of the RGB/gray/binary display stage.
- Consumes its threshold flag (th_flag), display pixel, pixel coordinates and sync signals.
- Finds the bounding box of all above-threshold pixels inside a detection window over one frame, latches that box at the frame boundary, and draws it as a coloured rectangle border on the following frame's video.
- Registered video passes on to the LCD timing/output stage.

Parameters:
BOX_COLOR, 24'hFF0000, RGB888 colour of the drawn border
LINE_W, 2, border thickness in pixels (1..8)
MIN_PIXELS, 64, minimum flagged-pixel count for a box to be valid
WIN_X0, 31, first x of detection window (inclusive)
WIN_X1, 449, last x of detection window (inclusive)
WIN_Y0, 31, first y of detection window (inclusive)
WIN_Y1, 239, last y of detection window (inclusive)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  overlay enable; 0 = video passes unmodified (tracking continues)
i_hs  in  1  line sync from upstream
i_vs  in  1  frame sync from upstream, active high
i_de  in  1  data enable from upstream
i_x  in  12  pixel x position
i_y  in  12  pixel y position
i_flag  in  1  binary pixel flag (th_flag of upstream)
i_data  in  24  RGB888 pixel from upstream
o_hs  out  1  i_hs delayed 1 cycle
o_vs  out  1  i_vs delayed 1 cycle
o_de  out  1  i_de delayed 1 cycle
o_data  out  24  pixel with overlay, 1-cycle latency
box_valid  out  1  latched box is valid
box_x0  out  12  latched box min x
box_x1  out  12  latched box max x
box_y0  out  12  latched box min y
box_y1  out  12  latched box max y
pix_count  out  20  flagged-pixel count of last completed frame, saturating

Behaviour:
- Reset: all outputs 0; accumulators cleared (min regs 12'hFFF, max 0, count 0); FSM in WAIT_FRAME.
- Frame event (fe): rising edge of i_vs, detected against a 1-cycle registered copy of i_vs.
- FSM WAIT_FRAME: no accumulation; on fe -> ACCUM with accumulators cleared. The partial frame after reset is always discarded.
- FSM ACCUM:
  - Sample qualifies when i_de=1, i_flag=1, and i_x in [WIN_X0,WIN_X1], i_y in [WIN_Y0,WIN_Y1].
  - Each qualifying sample updates min_x/max_x/min_y/max_y by unsigned compare and count += 1, saturating at 20'hFFFFF.
- On fe in ACCUM, in a single cycle:
  - pix_count <= count.
  - If count >= MIN_PIXELS: box_* <= accumulators and box_valid <= 1; else box_valid <= 0 and box_* hold old values.
  - Accumulators cleared; state stays ACCUM.
  - A qualifying sample in the fe cycle is dropped (not counted).
- Video path: o_hs/o_vs/o_de are 1-cycle registered copies of their inputs. o_data is registered:
  - o_data <= BOX_COLOR when en=1, box_valid=1, i_de=1 and the pixel is on the border; otherwise o_data <= i_data.
  - Border condition: x in [box_x0,box_x1] and y in [box_y0,box_y1] and (x < box_x0+LINE_W or x+LINE_W > box_x1 or y < box_y0+LINE_W or y+LINE_W > box_y1).
  - Additions are 13-bit, so there is no wrap at 4095.
  - When i_de=0, o_data <= 0.
- Degenerate boxes: a box with x0=x1 or y0=y1 is legal and drawn as a solid line or point.
- Overlay uses only the latched box. It never reflects the frame being accumulated.
- en only gates the overlay. Accumulation, latching and the status outputs are unaffected.
- Reset asserted mid-frame: everything returns to reset values immediately; the next fe re-enters ACCUM.
- Parameter legality: WIN_X0<=WIN_X1 and WIN_Y0<=WIN_Y1; otherwise no sample ever qualifies.

Test Plan:
- Reset release mid-frame, 100 flagged pixels in window, then fe -> box_valid=0 and pix_count=0; the first complete frame is required before any box.
- Full frame with a flagged 20x10 block at x 100..119, y 50..59 (200 px), then fe -> box_valid=1, box = (100,119,50,59), pix_count=200. On the next frame with en=1, LINE_W=2: pixel (100,55) and (110,51) are BOX_COLOR; pixel (102,55) passes i_data; output lags input by 1 cycle.
- Frame with 63 flagged pixels -> box_valid=0, pix_count=63, box_* unchanged; the next frame shows no overlay.
- Flagged pixels at x=10 and y=300 (outside window) plus an in-window block -> box excludes the outside pixels; flag asserted with i_de=0 is ignored.
- Flagged pixel in the exact fe cycle, plus en toggled 0 mid-frame -> pixel not counted; while en=0, o_data==i_data delayed, and box_valid is still updated at the next fe.
